// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor controller.
package serial_addsub_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub_cell.sv
// 1-bit add cell; sub inverts b so the same cell performs a + ~b + c.
module serial_addsub_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic sub,
    output logic s,
    output logic cout
);

    logic b_x;

    assign b_x  = b ^ sub;
    assign s    = a ^ b_x ^ cin;
    assign cout = (a & b_x) | (a & cin) | (b_x & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: one shared cell, LSB first, one bit per cycle.
// Define SERIAL_ADDSUB_OVF_EN to build the registered signed-overflow flag.
module serial_addsub_ctrl
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned      CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cell_s, cell_cout;

    serial_addsub_cell u_cell (
        .a    (a_q[cnt_q]),
        .b    (b_q[cnt_q]),
        .cin  (carry_q),
        .sub  (sub_q),
        .s    (cell_s),
        .cout (cell_cout)
    );

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    s_d     = '0;
                    cnt_d   = '0;
                    // Subtract is a + ~b + 1, so a borrow-in removes the +1.
                    carry_d = cin ^ sub;
`ifdef SERIAL_ADDSUB_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                s_d     = {cell_s, s_q[WIDTH-1:1]};
                carry_d = cell_cout;
                if (cnt_q == LAST) begin
                    state_d = DONE;
`ifdef SERIAL_ADDSUB_OVF_EN
                    ovf_d   = carry_q ^ cell_cout;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = carry_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf  = ovf_q;
`else
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl at WIDTH=8; ovf expectations follow SERIAL_ADDSUB_OVF_EN.
module tb_serial_addsub_ctrl;

    localparam int unsigned W = 8;
`ifdef SERIAL_ADDSUB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start, cin, sub;
    logic [W-1:0] a, b;
    logic         busy, done, cout, ovf;
    logic [W-1:0] s;

    int checks = 0;
    int errors = 0;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge after the start edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                            input logic tcin, input logic tsub);
        a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts remaining busy cycles, then checks the DONE cycle; ends inside DONE.
    task automatic finish_op(input string tag, input int n0, input logic [W-1:0] es,
                             input logic ecout, input logic eovf);
        int n = n0;
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        check_eq({tag, "_busy_cycles"}, n, W);
        check_eq({tag, "_done"}, done, 1'b1);
        check_eq({tag, "_s"}, s, es);
        check_eq({tag, "_cout"}, cout, ecout);
        check_eq({tag, "_ovf"}, ovf, OVF_EN & eovf);
    endtask

    task automatic expect_idle_hold(input string tag, input logic [W-1:0] es);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, done, 1'b0);
        check_eq({tag, "_idle"}, busy, 1'b0);
        check_eq({tag, "_s_hold"}, s, es);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_s", s, 0);
        check_eq("rst_cout", cout, 1'b0);
        check_eq("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        finish_op("add_5a_3c", 0, 8'h96, 1'b0, 1'b1);
        expect_idle_hold("add_5a_3c", 8'h96);

        start_op(8'hFF, 8'h01, 1'b0, 1'b0);
        finish_op("add_ff_01", 0, 8'h00, 1'b1, 1'b0);
        expect_idle_hold("add_ff_01", 8'h00);

        start_op(8'h00, 8'h01, 1'b0, 1'b1);
        finish_op("sub_00_01", 0, 8'hFF, 1'b0, 1'b0);
        expect_idle_hold("sub_00_01", 8'hFF);

        start_op(8'h80, 8'h01, 1'b0, 1'b1);
        finish_op("sub_80_01", 0, 8'h7F, 1'b1, 1'b1);
        @(negedge clk);

        start_op(8'h7F, 8'h00, 1'b1, 1'b0);
        finish_op("add_7f_cin", 0, 8'h80, 1'b0, 1'b1);
        @(negedge clk);

        start_op(8'h10, 8'h01, 1'b1, 1'b1);
        finish_op("sub_borrow", 0, 8'h0E, 1'b1, 1'b0);
        @(negedge clk);

        // Start and operand changes mid-run must be ignored.
        start_op(8'h10, 8'h01, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_op("ignore_start", 4, 8'h0F, 1'b1, 1'b0);
        @(negedge clk);

        // Reset mid-run aborts with no done pulse.
        start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_s", s, 0);
        check_eq("abort_cout", cout, 1'b0);
        check_eq("abort_ovf", ovf, 1'b0);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                seen = seen | done | busy;
            end
            check_eq("abort_no_done", seen, 1'b0);
        end

        // Back-to-back: restart from the DONE cycle with no idle gap.
        start_op(8'h01, 8'h02, 1'b0, 1'b0);
        finish_op("b2b_first", 0, 8'h03, 1'b0, 1'b0);
        start_op(8'h20, 8'h30, 1'b0, 1'b1);
        check_eq("b2b_busy_next", busy, 1'b1);
        finish_op("b2b_second", 0, 8'hF0, 1'b0, 1'b0);
        expect_idle_hold("b2b_second", 8'hF0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
